// File: rtl/fp_ctrl_pkg.sv
// Shared constants and types for the FP issue controller: major opcodes,
// FARITH funct5 classes, the FPU op encoding and the issue FSM state.
package fp_ctrl_pkg;

  localparam logic [4:0] OPC_FARITH = 5'b10100;
  localparam logic [4:0] OPC_FLW    = 5'b00001;
  localparam logic [4:0] OPC_FSW    = 5'b01001;

  localparam logic [4:0] F5_ADD = 5'b00000;
  localparam logic [4:0] F5_SUB = 5'b00001;
  localparam logic [4:0] F5_MUL = 5'b00010;
  localparam logic [4:0] F5_DIV = 5'b00011;

  typedef enum logic [1:0] {
    FOP_ADD = 2'b00,
    FOP_MUL = 2'b01,
    FOP_DIV = 2'b10
  } fpu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fp_state_e;

  function automatic int lat_max(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard for the 32 FP registers. Set beats clear on the
// same register; lookups treat a register being written back this cycle as free.
module fp_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set,
  input  logic [4:0] i_set_rd,
  input  logic       i_clr,
  input  logic [4:0] i_clr_rd,
  input  logic [4:0] i_rs_a,
  input  logic [4:0] i_rs_b,
  input  logic [4:0] i_rs_c,
  output logic       o_busy_a,
  output logic       o_busy_b,
  output logic       o_busy_c
);

  logic [31:0] r_pending;
  logic [31:0] w_pend_nxt;

  always_comb begin
    w_pend_nxt = r_pending;
    if (i_clr) begin
      w_pend_nxt[i_clr_rd] = 1'b0;
    end else begin
      w_pend_nxt = w_pend_nxt;
    end
    if (i_set) begin
      w_pend_nxt[i_set_rd] = 1'b1;
    end else begin
      w_pend_nxt = w_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

  // Write-back bypass: the datapath forwards the result, so it is not a hazard.
  assign o_busy_a = r_pending[i_rs_a] & ~(i_clr & (i_clr_rd == i_rs_a));
  assign o_busy_b = r_pending[i_rs_b] & ~(i_clr & (i_clr_rd == i_rs_b));
  assign o_busy_c = r_pending[i_rs_c] & ~(i_clr & (i_clr_rd == i_rs_c));

endmodule

// File: rtl/fp_issue_ctrl.sv
// ID-stage FP issue controller: decodes the instruction in ID, checks hazards
// against the scoreboard and sequences the single in-flight FARITH op.
module fp_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        ex_flush,
  output logic        stall,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  output logic        fpu_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd
);

  localparam int CNT_W = $clog2(lat_max(LAT_ADD, LAT_MUL, LAT_DIV) + 1);
  localparam logic [CNT_W-1:0] CNT_ADD = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(LAT_DIV - 1);

  fp_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_lat_m1;
  logic [4:0]       r_rd, w_rd_nxt;
  logic [4:0]       w_opc, w_f5, w_fs1, w_fs2, w_fd;
  logic             w_is_farith, w_is_flw, w_is_fsw;
  logic             w_fs1_busy, w_fs2_busy, w_fd_busy;
  logic             w_raw, w_waw, w_struct, w_live, w_wb;
  fpu_op_e          w_op;
  logic             w_unused;

  assign w_opc = id_inst[6:2];
  assign w_f5  = id_inst[31:27];
  assign w_fs1 = id_inst[19:15];
  assign w_fs2 = id_inst[24:20];
  assign w_fd  = id_inst[11:7];
  assign w_unused = ^{id_inst[1:0], id_inst[14:12], id_inst[26:25]};

  assign w_is_farith = (w_opc == OPC_FARITH);
  assign w_is_flw    = (w_opc == OPC_FLW);
  assign w_is_fsw    = (w_opc == OPC_FSW);

  always_comb begin
    w_op     = FOP_ADD;
    w_lat_m1 = CNT_ADD;
    case (w_f5)
      F5_ADD, F5_SUB: begin
        w_op     = FOP_ADD;
        w_lat_m1 = CNT_ADD;
      end
      F5_MUL: begin
        w_op     = FOP_MUL;
        w_lat_m1 = CNT_MUL;
      end
      F5_DIV: begin
        w_op     = FOP_DIV;
        w_lat_m1 = CNT_DIV;
      end
      default: begin
        w_op     = FOP_ADD;
        w_lat_m1 = CNT_ADD;
      end
    endcase
  end

  assign w_wb = (r_state == ST_BUSY) && (r_cnt == '0);

  fp_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .i_set    (fpu_start),
    .i_set_rd (w_fd),
    .i_clr    (w_wb),
    .i_clr_rd (r_rd),
    .i_rs_a   (w_fs1),
    .i_rs_b   (w_fs2),
    .i_rs_c   (w_fd),
    .o_busy_a (w_fs1_busy),
    .o_busy_b (w_fs2_busy),
    .o_busy_c (w_fd_busy)
  );

  // Hazards depend only on id_inst and registered state, never on fpu_start.
  assign w_raw    = (w_is_farith & (w_fs1_busy | w_fs2_busy)) | (w_is_fsw & w_fs2_busy);
  assign w_waw    = w_is_flw & w_fd_busy;
  assign w_struct = w_is_farith & (r_state == ST_BUSY) & (r_cnt != '0);
  assign w_live   = id_valid & ~ex_flush;

  assign stall     = w_live & (w_raw | w_waw | w_struct);
  assign fpu_start = w_live & ~stall & w_is_farith;
  assign fpu_op    = fpu_start ? w_op : FOP_ADD;
  assign fpu_busy  = (r_state == ST_BUSY);
  assign wb_valid  = w_wb;
  assign wb_rd     = w_wb ? r_rd : 5'd0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = r_rd;
    case (r_state)
      ST_IDLE: begin
        if (fpu_start) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = w_lat_m1;
          w_rd_nxt    = w_fd;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (fpu_start) begin
          w_cnt_nxt = w_lat_m1;
          w_rd_nxt  = w_fd;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rd    <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd    <= w_rd_nxt;
    end
  end

endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Issue controller for the floating-point datapath in the ID stage. It decodes the major opcode (inst[6:2]) of the instruction in ID and tracks the single in-flight multi-cycle FP arithmetic op. A 32-entry FP-register scoreboard detects RAW, WAW and structural hazards, and the block drives the pipeline stall, the FPU start pulse and the FP write-back strobe.

## Interface
Parameters:
- LAT_ADD, default 3: cycles for FADD/FSUB and all other FARITH funct5 values, ≥1.
- LAT_MUL, default 4: cycles for FMUL, ≥1.
- LAT_DIV, default 12: cycles for FDIV, ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- id_valid  in  1  ID stage holds a valid instruction.
- id_inst  in  32  instruction in ID.
- ex_flush  in  1  squash the ID instruction this cycle (branch/jump redirect).
- stall  out  1  hold IF/ID this cycle; combinational.
- fpu_start  out  1  one-cycle pulse, FARITH accepted this cycle; combinational.
- fpu_op  out  2  valid with fpu_start: 00 add/sub/other, 01 mul, 10 div.
- fpu_busy  out  1  registered; an FARITH is in flight.
- wb_valid  out  1  FPU result is written to FP regfile this cycle; registered state decode.
- wb_rd  out  5  destination FP register, valid with wb_valid.

## Operation
- Decode inst[6:2]:
  - 10100 FARITH: reads fs1 = inst[19:15] and fs2 = inst[24:20], writes fd = inst[11:7].
  - 00001 FLW: writes fd.
  - 01001 FSW: reads fs2.
  - Every other opcode is integer and never stalls.
- FARITH class from funct5 = inst[31:27]:
  - 00000/00001 → op 00, LAT_ADD.
  - 00010 → op 01, LAT_MUL.
  - 00011 → op 10, LAT_DIV.
  - Other values → op 00, LAT_ADD.
- Scoreboard: pending[31:0], one bit per FP register. f0 is a real register and is tracked.
- Source "busy" = pending bit set AND NOT (wb_valid AND wb_rd == that source). The datapath forwards the WB result.
- stall = id_valid & ~ex_flush & (RAW | WAW | STRUCT):
  - RAW: FARITH with fs1 or fs2 busy, or FSW with fs2 busy.
  - WAW: FLW with fd busy.
  - STRUCT: FARITH while state==BUSY and cnt != 0.
- accept = id_valid & ~ex_flush & ~stall. fpu_start = accept & FARITH.
- FSM states:
  - IDLE: on fpu_start, load cnt ← LAT−1, latch rd, set pending[fd], go to BUSY.
  - BUSY with cnt != 0: cnt ← cnt−1.
  - BUSY with cnt == 0: wb_valid=1 and pending[rd] is cleared at the edge. If fpu_start occurs in the same cycle, reload cnt, latch the new rd and stay in BUSY; otherwise go to IDLE.
- Simultaneous clear and set of the same register: set wins.
- cnt width is $clog2(max(LAT_*)+1).
- ex_flush only kills the ID instruction. It never cancels the in-flight op, which is older.

## Timing
- Reset values: state=IDLE, pending=0, cnt=0, fpu_busy=0, wb_valid=0, wb_rd=0, stall=0, fpu_start=0, fpu_op=00.
- Reset asserted mid-operation discards the in-flight op. No wb_valid is produced for it.
- If FARITH is accepted in cycle 0:
  - fpu_busy is 1 in cycles 1..LAT.
  - wb_valid is 1 in cycle LAT only.
  - A dependent reader issues in cycle LAT via forwarding.
  - The next FARITH issues no earlier than cycle LAT, so back-to-back ops have zero bubbles.
- LAT=1: wb_valid in cycle 1.
- Stall is combinational from id_inst and registered state. There is no self-loop: stall does not depend on fpu_start.

## Structure
- Package fp_ctrl_pkg holds:
  - Opcode constants OPC_FARITH=5'b10100, OPC_FLW=5'b00001, OPC_FSW=5'b01001.
  - funct5 constants F5_ADD, F5_SUB, F5_MUL, F5_DIV.
  - The fpu_op encoding.
  - The FSM state type.
- One sub-module, fp_scoreboard: 32-bit pending vector with set/clear ports (set priority) and three combinational read lookups that apply the wb bypass.

## Test plan
- FADD f3,f1,f2 accepted at cycle 0 with LAT_ADD=3 → fpu_start=1, fpu_op=00 in cycle 0; fpu_busy in cycles 1–3; wb_valid=1, wb_rd=3 in cycle 3 only.
- FDIV f5 issued, then FADD f6,f5,f1 held in ID → stall=1 in cycles 1–11 and 0 in cycle 12, with accept and fpu_start in cycle 12.
- FMUL f4, then FSW f4 and FLW f4 each held in ID → both stall until cycle 4 (RAW and WAW respectively). An integer ADD in ID during cycles 1–3 is not stalled.
- FADD f7 at cycle 0, then independent FMUL f8 in ID → stall in cycles 1–2; FMUL accepted in cycle 3 with wb_valid=1, wb_rd=7 in the same cycle; next wb_valid at cycle 7 with wb_rd=8.
- FADD f2, then FADD f2,f2,f2 accepted at the WB cycle (same-rd set/clear collision) → pending[2] stays 1 until the second WB.
- ex_flush=1 with a FARITH in ID → fpu_start=0, stall=0, pending unchanged. rst asserted at cycle 2 of an FDIV → next cycle all outputs 0 and wb_valid never fires.
